// File: rtl/psx_pad_responder.sv
// psx_pad_responder: device-side emulation of a digital PSX controller.
// It answers the standard digital poll with FF, PAD_ID, 5A and two button
// bytes. All host pins are oversampled by clk through 2-flop synchronizers.
module psx_pad_responder #(
  parameter logic [7:0] PAD_ID    = 8'h41,
  parameter int         ACK_DELAY = 4,
  parameter int         ACK_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic        att,
  input  logic [15:0] buttons,
  output logic        data,
  output logic        ack,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        selected
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ACK_WAIT,
    ST_ACK_PULSE,
    ST_MUTE
  } state_t;

  localparam logic [7:0] ACK_DELAY_LAST = 8'(ACK_DELAY - 1);
  localparam logic [7:0] ACK_WIDTH_LAST = 8'(ACK_WIDTH - 1);

  state_t      state_q, state_d;
  logic [2:0]  psx_pipe_q, psx_pipe_d;
  logic [1:0]  cmd_pipe_q, cmd_pipe_d;
  logic [2:0]  att_pipe_q, att_pipe_d;
  logic [1:0]  settle_q, settle_d;
  logic        armed_q, armed_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  ack_cnt_q, ack_cnt_d;
  // Bit 0 of the assembly is shifted out on the 8th rise, so only 7 bits are kept.
  logic [7:1]  rx_q, rx_d;
  logic [15:0] snap_q, snap_d;
  logic        data_q, data_d;
  logic        ack_q, ack_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        selected_q, selected_d;

  logic        cmd_s;
  logic        att_s;
  logic        psx_fall;
  logic        psx_rise;
  logic        att_fall;
  logic [7:0]  rx_next;
  logic [7:0]  reply_byte;

  // Index 1 of each pipe is the synchronized level, index 2 the delayed copy for edges.
  assign cmd_s    = cmd_pipe_q[1];
  assign att_s    = att_pipe_q[1];
  assign psx_fall = psx_pipe_q[2] & ~psx_pipe_q[1];
  assign psx_rise = ~psx_pipe_q[2] & psx_pipe_q[1];
  assign att_fall = att_pipe_q[2] & ~att_pipe_q[1];
  assign rx_next  = {cmd_s, rx_q};

  // Select the reply byte for the current position in the poll.
  always_comb begin
    reply_byte = 8'hFF;
    case (byte_idx_q)
      3'd0:    reply_byte = 8'hFF;
      3'd1:    reply_byte = PAD_ID;
      3'd2:    reply_byte = 8'h5A;
      3'd3:    reply_byte = snap_q[7:0];
      3'd4:    reply_byte = snap_q[15:8];
      default: reply_byte = 8'hFF;
    endcase
  end

  // Next-state logic for synchronizers, transaction FSM and registered outputs.
  always_comb begin
    psx_pipe_d  = {psx_pipe_q[1:0], psx_clk};
    cmd_pipe_d  = {cmd_pipe_q[0], cmd};
    att_pipe_d  = {att_pipe_q[1:0], att};
    // The synchronizers restart at 1 after reset, so a low att pin would look
    // like a fresh falling edge; only arm once att has genuinely been seen high.
    settle_d    = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d     = armed_q | (att_s & (settle_q == 2'd2));
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    bit_cnt_d   = bit_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    rx_d        = rx_q;
    snap_d      = snap_q;
    data_d      = data_q;
    ack_d       = ack_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;

    if (att_s) begin
      state_d = ST_IDLE;
      data_d  = 1'b1;
      ack_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          data_d = 1'b1;
          ack_d  = 1'b1;
          if (att_fall && armed_q) begin
            state_d    = ST_SHIFT;
            byte_idx_d = 3'd0;
            bit_cnt_d  = 3'd0;
            snap_d     = buttons;
          end
        end
        ST_SHIFT: begin
          if (psx_fall) begin
            data_d = reply_byte[bit_cnt_q];
          end else if (psx_rise) begin
            rx_d      = rx_next[7:1];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              cmd_byte_d  = rx_next;
              cmd_valid_d = 1'b1;
              if ((byte_idx_q == 3'd0 && rx_next != 8'h01) ||
                  (byte_idx_q == 3'd1 && rx_next != 8'h42) ||
                  (byte_idx_q == 3'd4)) begin
                state_d = ST_MUTE;
                data_d  = 1'b1;
              end else begin
                state_d   = ST_ACK_WAIT;
                ack_cnt_d = 8'd0;
              end
            end
          end
        end
        ST_ACK_WAIT: begin
          if (ack_cnt_q == ACK_DELAY_LAST) begin
            state_d   = ST_ACK_PULSE;
            ack_d     = 1'b0;
            ack_cnt_d = 8'd0;
          end else begin
            ack_cnt_d = ack_cnt_q + 8'd1;
          end
        end
        ST_ACK_PULSE: begin
          if (ack_cnt_q == ACK_WIDTH_LAST) begin
            state_d    = ST_SHIFT;
            ack_d      = 1'b1;
            ack_cnt_d  = 8'd0;
            bit_cnt_d  = 3'd0;
            byte_idx_d = byte_idx_q + 3'd1;
          end else begin
            ack_cnt_d = ack_cnt_q + 8'd1;
          end
        end
        ST_MUTE: begin
          data_d = 1'b1;
          ack_d  = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          data_d  = 1'b1;
          ack_d   = 1'b1;
        end
      endcase
    end

    selected_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      psx_pipe_q  <= 3'b111;
      cmd_pipe_q  <= 2'b11;
      att_pipe_q  <= 3'b111;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      byte_idx_q  <= 3'd0;
      bit_cnt_q   <= 3'd0;
      ack_cnt_q   <= 8'd0;
      rx_q        <= 7'd0;
      snap_q      <= 16'hFFFF;
      data_q      <= 1'b1;
      ack_q       <= 1'b1;
      cmd_byte_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      selected_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      psx_pipe_q  <= psx_pipe_d;
      cmd_pipe_q  <= cmd_pipe_d;
      att_pipe_q  <= att_pipe_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      byte_idx_q  <= byte_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      rx_q        <= rx_d;
      snap_q      <= snap_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      selected_q  <= selected_d;
    end
  end

  assign data      = data_q;
  assign ack       = ack_q;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_valid = cmd_valid_q;
  assign selected  = selected_q;

endmodule
